// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: resolves data wait, load-use, fetch miss
// and taken branch each cycle, latches halt, runs a data-wait watchdog and counts stalls.
module hazard_ctrl #(
   parameter int MAX_WAIT = 64,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmem_req,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             branch_taken,
   input  logic             halt_memwb,
   output logic             pc_WEN,
   output logic             WEN,
   output logic             ifid_WEN,
   output logic             ifid_FLUSH,
   output logic             idex_bubble,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_waitCnt;
   logic              r_memTimeout;
   logic [CNT_W-1:0]  r_stallCount;

   logic w_dstall;
   logic w_lu;
   logic w_pcWen;
   logic w_wen;
   logic w_ifidWen;
   logic w_ifidFlush;
   logic w_idexBubble;

   assign w_dstall = dmem_req & ~dhit;
   assign w_lu     = idex_memread & (idex_rd != 5'd0) &
                     ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next;
      end
   end

   // RUN and DWAIT share one priority chain; DWAIT only differs in how it is entered
   always_comb begin
      w_next       = r_state;
      w_pcWen      = 1'b0;
      w_wen        = 1'b0;
      w_ifidWen    = 1'b0;
      w_ifidFlush  = 1'b0;
      w_idexBubble = 1'b0;
      case (r_state)
         HALT: begin
            w_next = HALT;
         end
         default: begin
            if (halt_memwb) begin
               w_next = HALT;
            end else if (w_dstall) begin
               w_next = DWAIT;
            end else if (w_lu) begin
               w_next       = RUN;
               w_wen        = 1'b1;
               w_idexBubble = 1'b1;
            end else if (branch_taken) begin
               w_next      = RUN;
               w_pcWen     = 1'b1;
               w_wen       = 1'b1;
               w_ifidFlush = 1'b1;
            end else if (!ihit) begin
               w_next      = RUN;
               w_wen       = 1'b1;
               w_ifidFlush = 1'b1;
            end else begin
               w_next    = RUN;
               w_pcWen   = 1'b1;
               w_wen     = 1'b1;
               w_ifidWen = 1'b1;
            end
         end
      endcase
   end

   assign pc_WEN      = w_pcWen      & ~RST;
   assign WEN         = w_wen        & ~RST;
   assign ifid_WEN    = w_ifidWen    & ~RST;
   assign ifid_FLUSH  = w_ifidFlush  & ~RST;
   assign idex_bubble = w_idexBubble & ~RST;
   assign halted      = (r_state == HALT);
   assign mem_timeout = r_memTimeout;
   assign stall_count = r_stallCount;

   // Watchdog: length of the current unbroken data-stall run
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_waitCnt    <= '0;
         r_memTimeout <= 1'b0;
      end else begin
         if (w_dstall) begin
            if (r_waitCnt != WAIT_W'(MAX_WAIT)) begin
               r_waitCnt <= r_waitCnt + 1'b1;
            end
            if (r_waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
               r_memTimeout <= 1'b1;
            end
         end else begin
            r_waitCnt <= '0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stallCount <= '0;
      end else if ((r_state != HALT) && !w_pcWen && (r_stallCount != {CNT_W{1'b1}})) begin
         r_stallCount <= r_stallCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with a short watchdog and a
// narrow stall counter so timeout and saturation are reachable quickly.
module tb_hazard_ctrl;

   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 4;

   localparam logic [4:0] C_ZERO  = 5'b00000;
   localparam logic [4:0] C_NORM  = 5'b11100;
   localparam logic [4:0] C_LU    = 5'b01001;
   localparam logic [4:0] C_BR    = 5'b11010;
   localparam logic [4:0] C_FMISS = 5'b01010;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             ihit, dhit, dmem_req, idex_memread, branch_taken, halt_memwb;
   logic [4:0]       idex_rd, ifid_rs, ifid_rt;
   logic             pc_WEN, WEN, ifid_WEN, ifid_FLUSH, idex_bubble, halted, mem_timeout;
   logic [CNT_W-1:0] stall_count;
   logic [4:0]       ctrl;

   int nAsserts = 0;
   int nFails   = 0;

   assign ctrl = {pc_WEN, WEN, ifid_WEN, ifid_FLUSH, idex_bubble};

   always #5 CLK = ~CLK;

   hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
      .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .branch_taken(branch_taken), .halt_memwb(halt_memwb),
      .pc_WEN(pc_WEN), .WEN(WEN), .ifid_WEN(ifid_WEN), .ifid_FLUSH(ifid_FLUSH),
      .idex_bubble(idex_bubble), .halted(halted), .mem_timeout(mem_timeout),
      .stall_count(stall_count)
   );

   // Drive one cycle's worth of inputs; caller is positioned at a falling edge
   task automatic applyStimulus(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                                input logic [4:0] rt, input logic dreq, input logic dh,
                                input logic ih, input logic br, input logic hlt);
      idex_memread = mr;
      idex_rd      = rd;
      ifid_rs      = rs;
      ifid_rt      = rt;
      dmem_req     = dreq;
      dhit         = dh;
      ihit         = ih;
      branch_taken = br;
      halt_memwb   = hlt;
   endtask

   task automatic test_reset();
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_ZERO) begin
         nFails++; $display("[TB] FAIL reset_ctrl got=%b want=%b", ctrl, C_ZERO);
      end
      nAsserts++;
      if ({halted, mem_timeout, stall_count} !== '0) begin
         nFails++; $display("[TB] FAIL reset_regs got halted=%b tmo=%b cnt=%0d want 0/0/0",
                            halted, mem_timeout, stall_count);
      end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_normal();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
         #1;
         nAsserts++;
         if (ctrl !== C_NORM) begin
            nFails++; $display("[TB] FAIL normal_ctrl cyc=%0d got=%b want=%b", i, ctrl, C_NORM);
         end
         @(negedge CLK);
      end
      nAsserts++;
      if (stall_count !== 4'd0) begin
         nFails++; $display("[TB] FAIL normal_count got=%0d want=0", stall_count);
      end
   endtask

   task automatic test_load_use();
      applyStimulus(1, 5, 5, 3, 0, 1, 1, 0, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_LU) begin
         nFails++; $display("[TB] FAIL lu_ctrl got=%b want=%b", ctrl, C_LU);
      end
      @(negedge CLK);
      applyStimulus(0, 5, 5, 3, 0, 1, 1, 0, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_NORM || stall_count !== 4'd1) begin
         nFails++; $display("[TB] FAIL lu_release got ctrl=%b cnt=%0d want %b/1",
                            ctrl, stall_count, C_NORM);
      end
      @(negedge CLK);
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_NORM) begin
         nFails++; $display("[TB] FAIL lu_rd0 got=%b want=%b", ctrl, C_NORM);
      end
      @(negedge CLK);
      applyStimulus(1, 7, 2, 7, 0, 1, 1, 0, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_LU) begin
         nFails++; $display("[TB] FAIL lu_rt got=%b want=%b", ctrl, C_LU);
      end
      @(negedge CLK);
      nAsserts++;
      if (stall_count !== 4'd2) begin
         nFails++; $display("[TB] FAIL lu_count got=%0d want=2", stall_count);
      end
   endtask

   task automatic test_dmiss();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
         #1;
         nAsserts++;
         if (ctrl !== C_ZERO) begin
            nFails++; $display("[TB] FAIL dmiss_ctrl cyc=%0d got=%b want=%b", i, ctrl, C_ZERO);
         end
         @(negedge CLK);
      end
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_NORM || stall_count !== 4'd5) begin
         nFails++; $display("[TB] FAIL dmiss_release got ctrl=%b cnt=%0d want %b/5",
                            ctrl, stall_count, C_NORM);
      end
      @(negedge CLK);
      nAsserts++;
      if (mem_timeout !== 1'b0) begin
         nFails++; $display("[TB] FAIL dmiss_no_timeout got=%b want=0", mem_timeout);
      end
   endtask

   task automatic test_watchdog();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
         @(posedge CLK); #1;
         if (i == 2) begin
            nAsserts++;
            if (mem_timeout !== 1'b0) begin
               nFails++; $display("[TB] FAIL wd_early got=%b want=0", mem_timeout);
            end
         end
         @(negedge CLK);
      end
      nAsserts++;
      if (mem_timeout !== 1'b1 || stall_count !== 4'd9) begin
         nFails++; $display("[TB] FAIL wd_set got tmo=%b cnt=%0d want 1/9", mem_timeout, stall_count);
      end
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_NORM) begin
         nFails++; $display("[TB] FAIL wd_release got=%b want=%b", ctrl, C_NORM);
      end
      @(negedge CLK);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
      @(negedge CLK);
      nAsserts++;
      if (mem_timeout !== 1'b1) begin
         nFails++; $display("[TB] FAIL wd_sticky got=%b want=1", mem_timeout);
      end
   endtask

   task automatic test_branch();
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_BR) begin
         nFails++; $display("[TB] FAIL br_ihit0 got=%b want=%b", ctrl, C_BR);
      end
      @(negedge CLK);
      applyStimulus(1, 4, 4, 0, 0, 1, 1, 1, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_LU) begin
         nFails++; $display("[TB] FAIL br_vs_lu got=%b want=%b", ctrl, C_LU);
      end
      @(negedge CLK);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_FMISS) begin
         nFails++; $display("[TB] FAIL fetch_miss got=%b want=%b", ctrl, C_FMISS);
      end
      @(negedge CLK);
      nAsserts++;
      if (stall_count !== 4'd11) begin
         nFails++; $display("[TB] FAIL br_count got=%0d want=11", stall_count);
      end
   endtask

   task automatic test_halt();
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 1);
      #1;
      nAsserts++;
      if (ctrl !== C_ZERO || halted !== 1'b0) begin
         nFails++; $display("[TB] FAIL halt_entry got ctrl=%b halted=%b want %b/0", ctrl, halted, C_ZERO);
      end
      @(negedge CLK);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         nAsserts++;
         if (ctrl !== C_ZERO || halted !== 1'b1 || stall_count !== 4'd12) begin
            nFails++; $display("[TB] FAIL halt_hold cyc=%0d got ctrl=%b halted=%b cnt=%0d want %b/1/12",
                               i, ctrl, halted, stall_count, C_ZERO);
         end
         @(negedge CLK);
      end
      #2 RST = 1'b1;
      #1;
      nAsserts++;
      if (halted !== 1'b0 || stall_count !== 4'd0 || mem_timeout !== 1'b0 || ctrl !== C_ZERO) begin
         nFails++; $display("[TB] FAIL halt_async_rst got halted=%b cnt=%0d tmo=%b ctrl=%b want 0/0/0/%b",
                            halted, stall_count, mem_timeout, ctrl, C_ZERO);
      end
      @(negedge CLK);
      RST = 1'b0;
      #1;
      nAsserts++;
      if (ctrl !== C_NORM) begin
         nFails++; $display("[TB] FAIL halt_run_after_rst got=%b want=%b", ctrl, C_NORM);
      end
      @(negedge CLK);
   endtask

   task automatic test_saturate();
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 14; i++) @(negedge CLK);
      nAsserts++;
      if (stall_count !== 4'd14) begin
         nFails++; $display("[TB] FAIL sat_before got=%0d want=14", stall_count);
      end
      for (int i = 0; i < 4; i++) @(negedge CLK);
      nAsserts++;
      if (stall_count !== 4'd15 || mem_timeout !== 1'b1) begin
         nFails++; $display("[TB] FAIL sat_hold got cnt=%0d tmo=%b want 15/1", stall_count, mem_timeout);
      end
   endtask

   task automatic test_reset_dwait();
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
      @(posedge CLK);
      #2 RST = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
      #1;
      nAsserts++;
      if (ctrl !== C_ZERO || stall_count !== 4'd0 || mem_timeout !== 1'b0) begin
         nFails++; $display("[TB] FAIL dwait_async_rst got ctrl=%b cnt=%0d tmo=%b want %b/0/0",
                            ctrl, stall_count, mem_timeout, C_ZERO);
      end
      @(negedge CLK);
      RST = 1'b0;
      #1;
      nAsserts++;
      if (ctrl !== C_NORM) begin
         nFails++; $display("[TB] FAIL dwait_run_after_rst got=%b want=%b", ctrl, C_NORM);
      end
      @(negedge CLK);
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_normal();
      test_load_use();
      test_dmiss();
      test_watchdog();
      test_branch();
      test_halt();
      test_saturate();
      test_reset_dwait();
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
